kbd_scan_ctrl: RTL and testbench
================================

Name: kbd_scan_ctrl

Overview:
- Sequencing controller between the PS/2 byte receiver and the scan-code display path.
- Consumes raw set-2 scan bytes through a ready/valid handshake and strips the E0 (extended) and F0 (break) prefixes.
- Tracks the single currently-held key, suppresses typematic repeats, and counts distinct presses in two-digit BCD.
- Its key_code and key_held outputs drive the 7-segment code display directly; a released key reads as 8'h00.

Parameters:
- TIMEOUT, 1000000, idle cycles after a prefix byte before the prefix is discarded and the FSM returns to IDLE (20 ms at 50 MHz); minimum 2.
- CLEAR_ON_RELEASE, 1, 1 = key_code forced to 8'h00 while no key is held; 0 = key_code keeps the last held code.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- data_in  input  8  scan byte from the PS/2 receiver
- data_valid  input  1  data_in valid; source holds data_in/data_valid until accepted
- data_ready  output  1  controller can accept a byte
- key_code  output  8  held key's make code (see CLEAR_ON_RELEASE)
- key_ext  output  1  held key was E0-prefixed
- key_held  output  1  a key is currently held
- press_pulse  output  1  one-cycle pulse on a new (non-repeat) press
- release_pulse  output  1  one-cycle pulse on any complete break sequence
- press_cnt  output  8  BCD press count, [7:4] tens, [3:0] units, 00..99

Behaviour:
- Reset (asynchronous, any state):
  - FSM to IDLE; pending byte cleared; timeout counter cleared.
  - Output reset values: data_ready=1, key_code=00, key_ext=0, key_held=0, press_pulse=0, release_pulse=0, press_cnt=00.
- Handshake:
  - A byte is accepted on an edge where data_valid && data_ready; it is captured into a pending register.
  - data_ready is 0 for exactly the next cycle, while the pending byte is decoded; it returns to 1 the cycle after.
  - Throughput is one byte per 2 cycles. data_valid while data_ready=0 is ignored; the source holds it.
- Decode latency: byte accepted at edge N; FSM state, key_* outputs and pulses update at edge N+1. Pulses are high for the cycle after N+1 only.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte X -> make(X, ext=0), stay IDLE.
  - EXT: E0 -> EXT (duplicate ignored); F0 -> EXT_BRK; X -> make(X, ext=1), go IDLE.
  - BRK: X -> break(X, ext=0), go IDLE. E0 or F0 here is treated as the data byte X.
  - EXT_BRK: X -> break(X, ext=1), go IDLE.
- make(X, e):
  - If key_held && key_code_int==X && key_ext==e, it is a typematic repeat: no pulse, no count change.
  - Otherwise: key_code_int<=X, key_ext<=e, key_held<=1, press_pulse=1, press_cnt increments.
- press_cnt arithmetic: BCD increment; units 9 -> 0 with tens carry; 99 wraps to 00.
- break(X, e):
  - Always asserts release_pulse.
  - If key_held && key_code_int==X && key_ext==e: key_held<=0; key_ext<=0 when CLEAR_ON_RELEASE=1.
  - Non-matching break: held state unchanged.
- key_code output: CLEAR_ON_RELEASE=1 gives key_held ? key_code_int : 00; CLEAR_ON_RELEASE=0 gives key_code_int.
- Timeout:
  - In EXT, BRK or EXT_BRK, the counter increments each cycle with no accepted byte and clears on accept.
  - On reaching TIMEOUT-1 the FSM returns to IDLE with no pulses; held state is untouched.
  - The counter is held at 0 in IDLE.
- Simultaneous events: a timeout expiry on the same edge that a byte is accepted is overridden; the byte is accepted and later decoded in the pre-timeout state.

Test Plan:
- Reset mid-sequence: send E0 F0, then assert rst asynchronously between clock edges -> all outputs at reset values immediately; FSM in IDLE; next byte 1C gives key_code=1C, key_ext=0.
- Basic press/release: bytes 1C, F0, 1C -> press_pulse once; key_code=1C, key_held=1, press_cnt=01; after the break, release_pulse once, key_code=00, key_held=0.
- Typematic: bytes 1C, 1C, 1C, F0, 1C -> exactly one press_pulse; press_cnt=01; one release_pulse.
- Extended key: bytes E0, 75, E0, F0, 75 -> key_code=75 with key_ext=1 while held; release clears key_held; a plain 75 afterwards is a new press (cnt +1).
- Handshake/timing: hold data_valid continuously with a new byte each accept -> data_ready pattern 1,0,1,0; outputs update exactly one edge after each accept.
- Wrap and timeout (TIMEOUT=8):
  - 100 distinct alternating press/release pairs -> press_cnt reads 99, then 00.
  - Send F0 then idle 8 cycles, then 1C -> treated as a make (press_pulse, not release_pulse).

Source files
------------

// File: rtl/kbd_scan_ctrl.sv
// kbd_scan_ctrl: PS/2 set-2 scan byte sequencer.
// Strips E0/F0 prefixes, tracks the single held key, filters typematic repeats
// and keeps a two-digit BCD count of distinct presses.
module kbd_scan_ctrl #(
  parameter int TIMEOUT          = 1000000,
  parameter bit CLEAR_ON_RELEASE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_held,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state, nxt_state;
  logic [7:0]    pend;
  logic [7:0]    code_int;
  logic [TW-1:0] tmr;
  logic          accept;
  logic          do_make, do_brk, dec_ext, match;

  // data_ready low means a byte sits in pend and is decoded this cycle
  assign accept = data_valid && data_ready;
  assign match  = key_held && (code_int == pend) && (key_ext == dec_ext);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      bcd_inc = (v[7:4] == 4'd9) ? 8'h00 : {v[7:4] + 4'd1, 4'h0};
    else
      bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // decode of the pending byte against the current prefix state
  always_comb begin
    nxt_state = state;
    do_make   = 1'b0;
    do_brk    = 1'b0;
    dec_ext   = 1'b0;
    if (!data_ready) begin
      case (state)
        IDLE: begin
          if (pend == 8'hE0)      nxt_state = EXT;
          else if (pend == 8'hF0) nxt_state = BRK;
          else                    do_make   = 1'b1;
        end
        EXT: begin
          dec_ext = 1'b1;
          if (pend == 8'hE0)      nxt_state = EXT;
          else if (pend == 8'hF0) nxt_state = EXT_BRK;
          else begin
            do_make   = 1'b1;
            nxt_state = IDLE;
          end
        end
        BRK: begin
          do_brk    = 1'b1;
          nxt_state = IDLE;
        end
        default: begin
          dec_ext   = 1'b1;
          do_brk    = 1'b1;
          nxt_state = IDLE;
        end
      endcase
    end
  end

  // handshake, prefix FSM, prefix timeout and held-key bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pend          <= 8'h00;
      tmr           <= '0;
      data_ready    <= 1'b1;
      code_int      <= 8'h00;
      key_ext       <= 1'b0;
      key_held      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_cnt     <= 8'h00;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;

      if (accept) begin
        pend       <= data_in;
        data_ready <= 1'b0;
      end else if (!data_ready) begin
        data_ready <= 1'b1;
      end

      // a stale prefix is dropped; an accept on the same edge wins
      if (state == IDLE || accept) begin
        tmr <= '0;
      end else if (tmr == TMR_LAST) begin
        tmr <= '0;
        if (data_ready) state <= IDLE;
      end else begin
        tmr <= tmr + 1'b1;
      end

      if (!data_ready) state <= nxt_state;

      if (do_make && !match) begin
        code_int    <= pend;
        key_ext     <= dec_ext;
        key_held    <= 1'b1;
        press_pulse <= 1'b1;
        press_cnt   <= bcd_inc(press_cnt);
      end

      if (do_brk) begin
        release_pulse <= 1'b1;
        if (match) begin
          key_held <= 1'b0;
          if (CLEAR_ON_RELEASE) key_ext <= 1'b0;
        end
      end
    end
  end

  assign key_code = (CLEAR_ON_RELEASE && !key_held) ? 8'h00 : code_int;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// tb_kbd_scan_ctrl: directed plus randomized checks against a byte-level model.
module tb_kbd_scan_ctrl;

  localparam int TIMEOUT = 8;
  localparam int LONG_IDLE = TIMEOUT + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_held;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_cnt;

  int tests = 0;
  int fails = 0;

  // reference model state: prefix flags plus held key and a plain integer count
  bit       m_pe, m_pb;
  bit [7:0] m_code;
  bit       m_kext, m_held;
  int       m_cnt;

  kbd_scan_ctrl #(.TIMEOUT(TIMEOUT), .CLEAR_ON_RELEASE(1'b1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .key_code(key_code), .key_ext(key_ext),
    .key_held(key_held), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    to_bcd = 8'((n / 10) % 10) << 4 | 8'(n % 10);
  endfunction

  task automatic model_reset();
    m_pe = 0; m_pb = 0; m_code = 0; m_kext = 0; m_held = 0; m_cnt = 0;
  endtask

  task automatic model_byte(input bit [7:0] b, output bit p, output bit r);
    p = 0; r = 0;
    if (m_pb) begin
      r = 1;
      if (m_held && m_code == b && m_kext == m_pe) begin
        m_held = 0; m_kext = 0;
      end
      m_pe = 0; m_pb = 0;
    end else if (b == 8'hE0) begin
      m_pe = 1;
    end else if (b == 8'hF0) begin
      m_pb = 1;
    end else begin
      if (!(m_held && m_code == b && m_kext == m_pe)) begin
        m_code = b; m_kext = m_pe; m_held = 1; p = 1;
        m_cnt = (m_cnt + 1) % 100;
      end
      m_pe = 0;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_code"}, 32'(key_code), 32'(m_held ? m_code : 8'h00));
    chk({tag, "_ext"},  32'(key_ext),  32'(m_kext));
    chk({tag, "_held"}, 32'(key_held), 32'(m_held));
    chk({tag, "_cnt"},  32'(press_cnt), 32'(to_bcd(m_cnt)));
  endtask

  // one byte through the handshake; checks ready timing, pulses and outputs
  task automatic send(input bit [7:0] b, input string tag);
    int w;
    bit p, r;
    w = 0;
    while (!data_ready && w < 10) begin @(negedge clk); w++; end
    chk({tag, "_rdy_wait"}, 32'(data_ready), 32'd1);
    data_in = b; data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    chk({tag, "_rdy_lo"}, 32'(data_ready), 32'd0);
    model_byte(b, p, r);
    @(posedge clk); #1;
    chk({tag, "_rdy_hi"}, 32'(data_ready), 32'd1);
    chk({tag, "_press"}, 32'(press_pulse), 32'(p));
    chk({tag, "_rel"}, 32'(release_pulse), 32'(r));
    check_outs(tag);
    @(posedge clk); #1;
    chk({tag, "_pclr"}, 32'({press_pulse, release_pulse}), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
    if (n >= LONG_IDLE) begin m_pe = 0; m_pb = 0; end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    bit [7:0] hs [4];
    bit p, r;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // reset state
    chk("rst_ready", 32'(data_ready), 32'd1);
    chk("rst_pulses", 32'({press_pulse, release_pulse}), 32'd0);
    check_outs("rst");

    // basic press/release
    send(8'h1C, "basic_make");
    chk("basic_cnt01", 32'(press_cnt), 32'h01);
    send(8'hF0, "basic_f0");
    send(8'h1C, "basic_brk");
    chk("basic_code00", 32'(key_code), 32'h00);

    // typematic repeats
    send(8'h1C, "typ_m1");
    send(8'h1C, "typ_m2");
    send(8'h1C, "typ_m3");
    chk("typ_cnt02", 32'(press_cnt), 32'h02);
    send(8'hF0, "typ_f0");
    send(8'h1C, "typ_brk");

    // extended key, then the same code unextended is a new press
    send(8'hE0, "ext_e0");
    send(8'h75, "ext_make");
    chk("ext_flag", 32'({key_ext, key_code}), 32'h175);
    send(8'hE0, "ext_e0b");
    send(8'hF0, "ext_f0");
    send(8'h75, "ext_brk");
    send(8'h75, "ext_plain");
    chk("ext_plain_cnt", 32'(press_cnt), 32'h04);

    // back-to-back with data_valid held high
    hs[0] = 8'h15; hs[1] = 8'h1D; hs[2] = 8'h24; hs[3] = 8'h00;
    data_in = hs[0]; data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("hs_rdy1", 32'(data_ready), 32'd1);
      @(posedge clk); #1;
      chk("hs_rdy0", 32'(data_ready), 32'd0);
      chk("hs_hold_code", 32'(key_code), 32'(m_held ? m_code : 8'h00));
      model_byte(hs[i], p, r);
      @(posedge clk); #1;
      chk("hs_rdy_back", 32'(data_ready), 32'd1);
      chk("hs_press", 32'(press_pulse), 32'(p));
      check_outs("hs");
      if (i < 2) data_in = hs[i+1];
      else data_valid = 1'b0;
    end
    idle(1);

    // asynchronous reset in the middle of E0 F0
    send(8'hE0, "mid_e0");
    send(8'hF0, "mid_f0");
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_ready", 32'(data_ready), 32'd1);
    chk("mid_rst_pulses", 32'({press_pulse, release_pulse}), 32'd0);
    check_outs("mid_rst");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send(8'h1C, "mid_after");
    chk("mid_after_code", 32'({key_ext, key_code}), 32'h01C);

    // randomized byte stream with occasional prefix timeouts
    for (int i = 0; i < 150; i++) begin
      int sel;
      bit [7:0] b;
      sel = $urandom_range(0, 9);
      if (sel < 2) b = 8'hE0;
      else if (sel < 4) b = 8'hF0;
      else if (sel < 6) b = 8'h1C;
      else if (sel < 7) b = 8'h75;
      else b = 8'($urandom);
      send(b, "rnd");
      if ($urandom_range(0, 7) == 0) idle(LONG_IDLE);
      else idle($urandom_range(0, 2));
    end

    // BCD wrap: 99 presses read 99, the 100th reads 00
    do_reset();
    for (int i = 0; i < 100; i++) begin
      bit [7:0] c;
      c = 8'h10 + 8'(i % 64);
      send(c, "wrap_make");
      if (i == 98) chk("wrap_99", 32'(press_cnt), 32'h99);
      if (i == 99) chk("wrap_00", 32'(press_cnt), 32'h00);
      send(8'hF0, "wrap_f0");
      send(c, "wrap_brk");
    end

    // stale F0 dropped after the timeout; 1C then is a make
    send(8'hF0, "to_f0");
    idle(LONG_IDLE);
    send(8'h1C, "to_make");
    chk("to_is_make", 32'(key_held), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
